soc_network_adapter_config_arbiter: RTL and testbench
=====================================================

Name: soc_network_adapter_config_arbiter

Overview:
- Shares the single AHB-Lite slave port of the network-adapter configuration register block between MASTERS requesters (cores of one tile, plus debug).
- Provides round-robin arbitration and registered address/data-phase sequencing.
- Generates proper two-cycle AHB ERROR responses for slave errors and for slave stalls that exceed a timeout.
- Sits between the tile-local bus masters and the configuration slave.

Parameters:
XLEN, 32, data width
MASTERS, 2, number of requesters (2..8)
TIMEOUT, 64, max data-phase wait cycles before forced ERROR (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low: sampled only at rising clk, rst==0 resets
m_hsel  in  MASTERS  per-master select
m_haddr  in  16*MASTERS  per-master address, master k at [16k+15:16k]
m_hwdata  in  XLEN*MASTERS  per-master write data
m_hwrite  in  MASTERS  per-master write
m_htrans  in  2*MASTERS  per-master transfer type
m_hmastlock  in  MASTERS  per-master locked-sequence request
m_hrdata  out  XLEN  read data, broadcast to all masters
m_hready  out  MASTERS  per-master ready
m_hresp  out  MASTERS  per-master error response
s_hsel  out  1  slave select
s_haddr  out  16  slave address
s_hwdata  out  XLEN  slave write data
s_hwrite  out  1  slave write
s_htrans  out  2  slave transfer type
s_hrdata  in  XLEN  slave read data
s_hready  in  1  slave ready
s_hresp  in  1  slave error

Behaviour:
- Request: req[k] = m_hsel[k] & m_htrans[k][1] (NONSEQ/SEQ).
- Non-granted requesters see m_hready[k]=0 and must hold their address/control stable.
- Idle masters (req[k]=0) see m_hready[k]=1, m_hresp[k]=0.
- Reset values (rst==0): state IDLE, grant=0, last=MASTERS-1, m_hready all 1, m_hresp all 0, m_hrdata 0, s_hsel 0, s_htrans 2'b00, s_haddr 0, s_hwrite 0, s_hwdata 0, timeout count 0.
- Reset mid-transfer abandons the transfer with no response.
- FSM states: IDLE, ADDR, DATA, ERR1, ERR2.
- IDLE:
  - If any req, grant = first requesting index searched from last+1 upward, wrapping modulo MASTERS.
  - Latch that master's haddr, hwrite, htrans; go to ADDR.
  - Requesting masters see m_hready=0 in this cycle.
- ADDR (1 cycle):
  - s_hsel=1, s_htrans=2'b10, latched address/control on s_*.
  - Go to DATA; clear counter.
- DATA:
  - s_hsel=0, s_htrans=0; s_hwdata = m_hwdata of grant.
  - s_hready=1 & s_hresp=0: m_hready[grant]=1, m_hrdata=s_hrdata (reads), last=grant.
    - Then IDLE, or ADDR directly (re-latching grant's address) if m_hmastlock[grant]=1 and req[grant]=1. Lock bypasses round-robin.
  - s_hresp=1: go to ERR1.
  - s_hready=0 & s_hresp=0: increment counter; at count==TIMEOUT-1 go to ERR1.
- ERR1: m_hready[grant]=0, m_hresp[grant]=1; go to ERR2.
- ERR2: m_hready[grant]=1, m_hresp[grant]=1; last=grant; go to IDLE. Error clears any lock.
- Minimum access latency: request in cycle 0, m_hready[grant]=1 in cycle 2 given s_hready=1.
- m_hrdata holds its last completed value outside completion cycles.
- Simultaneous requests are served strictly in round-robin order; no starvation without lock.
- Locked sequences end when hmastlock drops.
- Counter width = clog2(TIMEOUT)+1; it saturates and never wraps.
- MASTERS=1 degenerates to a pipeline register with timeout.

Test Plan:
- Reset with rst=0 for 2 cycles, then 1 → all m_hready=1, m_hresp=0, s_hsel=0, s_htrans=0.
- Master0 reads 0x0004 with slave ready, returning 0x10 → s_hsel=1 with s_haddr=0x0004 in cycle 1; m_hready[0]=1 and m_hrdata=0x10 in cycle 2.
- Masters 0 and 1 request continuously from reset → grants alternate 0,1,0,1; each completion is 3 cycles apart; the non-granted master sees m_hready=0 throughout.
- Master1 holds hmastlock=1 for 3 back-to-back reads while master0 also requests → three consecutive grants to master1, then master0.
- Slave returns s_hresp=1 in the data phase → master sees hready=0/hresp=1, then hready=1/hresp=1; FSM returns to IDLE; next request is served normally.
- Slave holds s_hready=0 with TIMEOUT=64 → ERR1 entered exactly 64 cycles after DATA entry; two-cycle error follows; asserting rst=0 during DATA returns all outputs to reset values next cycle.

Source files
------------

// File: rtl/soc_network_adapter_config_arbiter_if.sv
// soc_network_adapter_config_arbiter_if: tile-master and config-slave AHB-Lite signals of the arbiter
interface soc_network_adapter_config_arbiter_if #(
  parameter int XLEN = 32,
  parameter int MASTERS = 2
);
  logic [MASTERS-1:0] m_hsel;
  logic [16*MASTERS-1:0] m_haddr;
  logic [XLEN*MASTERS-1:0] m_hwdata;
  logic [MASTERS-1:0] m_hwrite;
  logic [2*MASTERS-1:0] m_htrans;
  logic [MASTERS-1:0] m_hmastlock;
  logic [XLEN-1:0] m_hrdata;
  logic [MASTERS-1:0] m_hready;
  logic [MASTERS-1:0] m_hresp;
  logic s_hsel;
  logic [15:0] s_haddr;
  logic [XLEN-1:0] s_hwdata;
  logic s_hwrite;
  logic [1:0] s_htrans;
  logic [XLEN-1:0] s_hrdata;
  logic s_hready;
  logic s_hresp;
  modport slave (
    input m_hsel, m_haddr, m_hwdata, m_hwrite, m_htrans, m_hmastlock, s_hrdata, s_hready, s_hresp,
    output m_hrdata, m_hready, m_hresp, s_hsel, s_haddr, s_hwdata, s_hwrite, s_htrans
  );
  modport master (
    output m_hsel, m_haddr, m_hwdata, m_hwrite, m_htrans, m_hmastlock, s_hrdata, s_hready, s_hresp,
    input m_hrdata, m_hready, m_hresp, s_hsel, s_haddr, s_hwdata, s_hwrite, s_htrans
  );
endinterface

// File: rtl/soc_network_adapter_config_arbiter.sv
// soc_network_adapter_config_arbiter: round-robin AHB-Lite arbiter in front of the adapter config slave
module soc_network_adapter_config_arbiter #(
  parameter int XLEN = 32,
  parameter int MASTERS = 2,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  soc_network_adapter_config_arbiter_if.slave bus
);
  localparam int GW = MASTERS > 1 ? $clog2(MASTERS) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, ERR1, ERR2} state_t;
  state_t state, state_n;
  logic [GW-1:0] grant, grant_n, last, last_n, pick, lidx;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0] addr_q;
  logic write_q;
  logic [1:0] trans_q;
  logic [XLEN-1:0] rdata_q;
  logic [MASTERS-1:0] req, hready, hresp;
  logic done, latch;
  // requests are masked while reset is held so every master sees an idle bus
  always_comb begin
    for (int k = 0; k < MASTERS; k++) req[k] = rst & bus.m_hsel[k] & bus.m_htrans[2*k+1];
  end
  // first requester after the last served one, wrapping; smallest distance wins
  always_comb begin
    pick = last;
    for (int i = MASTERS; i >= 1; i--)
      if (req[(int'(last) + i) % MASTERS]) pick = GW'((int'(last) + i) % MASTERS);
  end
  assign done = state == DATA && bus.s_hready && !bus.s_hresp;
  assign lidx = state == IDLE ? pick : grant;
  // transfer sequencing, lock continuation and data-phase timeout
  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n = last;
    cnt_n = cnt;
    latch = 1'b0;
    case (state)
      IDLE: if (|req) begin
        grant_n = pick;
        latch = 1'b1;
        state_n = ADDR;
      end
      ADDR: begin
        cnt_n = '0;
        state_n = DATA;
      end
      DATA: if (bus.s_hresp) state_n = ERR1;
      else if (bus.s_hready) begin
        last_n = grant;
        latch = bus.m_hmastlock[grant] & req[grant];
        state_n = latch ? ADDR : IDLE;
      end else begin
        cnt_n = &cnt ? cnt : cnt + 1'b1;
        if (cnt == CW'(TIMEOUT - 1)) state_n = ERR1;
      end
      ERR1: state_n = ERR2;
      ERR2: begin
        last_n = grant;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, arbitration history and latched address phase
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
      last <= GW'(MASTERS - 1);
      cnt <= '0;
      addr_q <= '0;
      write_q <= 1'b0;
      trans_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      last <= last_n;
      cnt <= cnt_n;
      if (latch) begin
        addr_q <= bus.m_haddr[16*int'(lidx) +: 16];
        write_q <= bus.m_hwrite[lidx];
        trans_q <= bus.m_htrans[2*int'(lidx) +: 2];
      end
      if (done && !write_q) rdata_q <= bus.s_hrdata;
    end
  end
  // waiting requesters stall; the granted master follows the data/error phase
  always_comb begin
    for (int k = 0; k < MASTERS; k++) begin
      hready[k] = !req[k];
      hresp[k] = 1'b0;
      if (GW'(k) == grant && state != IDLE) begin
        hready[k] = state == DATA ? done : state == ERR2;
        hresp[k] = state == ERR1 || state == ERR2;
      end
    end
  end
  assign bus.m_hready = hready;
  assign bus.m_hresp = hresp;
  assign bus.m_hrdata = done && !write_q ? bus.s_hrdata : rdata_q;
  assign bus.s_hsel = state == ADDR;
  assign bus.s_htrans = state == ADDR ? trans_q & 2'b10 : 2'b00;
  assign bus.s_haddr = addr_q;
  assign bus.s_hwrite = write_q;
  assign bus.s_hwdata = state == DATA ? bus.m_hwdata[XLEN*int'(grant) +: XLEN] : '0;
endmodule

// File: tb/tb_soc_network_adapter_config_arbiter.sv
// tb_soc_network_adapter_config_arbiter: directed and randomized checks of the config arbiter
module tb_soc_network_adapter_config_arbiter;
  localparam int XLEN = 32;
  localparam int MASTERS = 2;
  localparam int TIMEOUT = 64;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  soc_network_adapter_config_arbiter_if #(.XLEN(XLEN), .MASTERS(MASTERS)) bus ();
  soc_network_adapter_config_arbiter #(.XLEN(XLEN), .MASTERS(MASTERS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  logic [1:0] lock_hr [10] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b11};
  bit pv [2], pv_drv [2], pv_prev [2];
  logic [15:0] pa [2];
  logic pw [2];
  logic [31:0] pd [2];
  logic [31:0] ref_mem [16], slv_mem [16];
  int rr_last, exp_g, stall_left, ncomp, bad;
  bit in_data, err_inj, exp_err, s_w;
  logic [3:0] s_a;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask
  task automatic set_req(input int k, input logic [15:0] a, input logic w, input logic [31:0] d, input logic lk);
    bus.m_hsel[k] = 1'b1;
    bus.m_htrans[2*k +: 2] = 2'b10;
    bus.m_haddr[16*k +: 16] = a;
    bus.m_hwrite[k] = w;
    bus.m_hwdata[32*k +: 32] = d;
    bus.m_hmastlock[k] = lk;
  endtask
  task automatic drop(input int k);
    bus.m_hsel[k] = 1'b0;
    bus.m_htrans[2*k +: 2] = 2'b00;
    bus.m_hmastlock[k] = 1'b0;
  endtask
  initial begin
    bus.m_hsel = '0;
    bus.m_htrans = '0;
    bus.m_hmastlock = '0;
    bus.m_hwrite = '0;
    bus.m_haddr = '0;
    bus.m_hwdata = '0;
    bus.s_hrdata = '0;
    bus.s_hready = 1'b1;
    bus.s_hresp = 1'b0;
    // reset
    smp();
    chk("rst_hready", bus.m_hready, 2'b11);
    chk("rst_hresp", bus.m_hresp, 2'b00);
    repeat (2) cyc();
    rst = 1'b1;
    smp();
    chk("idle_hready", bus.m_hready, 2'b11);
    chk("idle_hresp", bus.m_hresp, 2'b00);
    chk("idle_shsel", bus.s_hsel, 1'b0);
    chk("idle_shtrans", bus.s_htrans, 2'b00);
    chk("idle_hrdata", bus.m_hrdata, 32'h0);
    // single read by master 0
    cyc();
    set_req(0, 16'h0004, 1'b0, 32'h0, 1'b0);
    bus.s_hrdata = 32'h10;
    smp();
    chk("rd_c0_hready0", bus.m_hready[0], 1'b0);
    cyc();
    smp();
    chk("rd_c1_shsel", bus.s_hsel, 1'b1);
    chk("rd_c1_shaddr", bus.s_haddr, 16'h0004);
    chk("rd_c1_shtrans", bus.s_htrans, 2'b10);
    cyc();
    smp();
    chk("rd_c2_hready0", bus.m_hready[0], 1'b1);
    chk("rd_c2_hrdata", bus.m_hrdata, 32'h10);
    cyc();
    drop(0);
    bus.s_hrdata = 32'hdead;
    smp();
    chk("rd_hold_hrdata", bus.m_hrdata, 32'h10);
    chk("rd_after_hready", bus.m_hready, 2'b11);
    // two masters requesting continuously from reset
    cyc();
    rst = 1'b0;
    set_req(0, 16'h0100, 1'b0, 32'h0, 1'b0);
    set_req(1, 16'h0200, 1'b0, 32'h0, 1'b0);
    cyc();
    cyc();
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      smp();
      chk("rr_alt_hready", bus.m_hready, c % 3 == 2 ? 2'b01 << ((c / 3) % 2) : 2'b00);
      cyc();
    end
    drop(0);
    drop(1);
    // locked sequence by master 1 with master 0 competing
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (c == 0) set_req(1, 16'h00b0, 1'b0, 32'h0, 1'b1);
      if (c == 1) set_req(0, 16'h00a0, 1'b0, 32'h0, 1'b0);
      if (c == 5) bus.m_hmastlock[1] = 1'b0;
      if (c == 7) drop(1);
      smp();
      chk("lock_hready", bus.m_hready, lock_hr[c]);
      if (c == 1 || c == 3 || c == 5 || c == 8) begin
        chk("lock_shsel", bus.s_hsel, 1'b1);
        chk("lock_shaddr", bus.s_haddr, c == 8 ? 16'h00a0 : 16'h00b0);
      end
    end
    cyc();
    drop(0);
    // slave error response
    cyc();
    set_req(0, 16'h0020, 1'b0, 32'h0, 1'b0);
    smp();
    cyc();
    smp();
    cyc();
    bus.s_hresp = 1'b1;
    bus.s_hready = 1'b0;
    smp();
    chk("err_data_hready0", bus.m_hready[0], 1'b0);
    cyc();
    bus.s_hresp = 1'b0;
    bus.s_hready = 1'b1;
    smp();
    chk("err1_hready0", bus.m_hready[0], 1'b0);
    chk("err1_hresp0", bus.m_hresp[0], 1'b1);
    cyc();
    smp();
    chk("err2_hready0", bus.m_hready[0], 1'b1);
    chk("err2_hresp0", bus.m_hresp[0], 1'b1);
    cyc();
    drop(0);
    set_req(1, 16'h0030, 1'b0, 32'h0, 1'b0);
    bus.s_hrdata = 32'h55;
    smp();
    chk("post_err_hresp", bus.m_hresp, 2'b00);
    cyc();
    smp();
    chk("post_err_shsel", bus.s_hsel, 1'b1);
    chk("post_err_shaddr", bus.s_haddr, 16'h0030);
    cyc();
    smp();
    chk("post_err_hready1", bus.m_hready[1], 1'b1);
    chk("post_err_hrdata", bus.m_hrdata, 32'h55);
    cyc();
    drop(1);
    // data-phase timeout
    cyc();
    set_req(0, 16'h0040, 1'b1, 32'hcafef00d, 1'b0);
    bus.s_hready = 1'b0;
    cyc();
    cyc();
    bad = 0;
    for (int c = 2; c < 66; c++) begin
      smp();
      if (c == 2) chk("to_shwdata", bus.s_hwdata, 32'hcafef00d);
      if (bus.m_hready[0] !== 1'b0 || bus.m_hresp[0] !== 1'b0) bad++;
      cyc();
    end
    smp();
    chk("to_wait_cycles", bad, 0);
    chk("to_err1_hready0", bus.m_hready[0], 1'b0);
    chk("to_err1_hresp0", bus.m_hresp[0], 1'b1);
    cyc();
    smp();
    chk("to_err2_hready0", bus.m_hready[0], 1'b1);
    chk("to_err2_hresp0", bus.m_hresp[0], 1'b1);
    cyc();
    drop(0);
    bus.s_hready = 1'b1;
    // reset in the middle of a data phase
    cyc();
    set_req(1, 16'h0050, 1'b1, 32'h1234, 1'b0);
    bus.s_hready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    smp();
    chk("mid_rst_hready", bus.m_hready, 2'b11);
    chk("mid_rst_hresp", bus.m_hresp, 2'b00);
    chk("mid_rst_shsel", bus.s_hsel, 1'b0);
    chk("mid_rst_shtrans", bus.s_htrans, 2'b00);
    chk("mid_rst_shaddr", bus.s_haddr, 16'h0);
    chk("mid_rst_shwrite", bus.s_hwrite, 1'b0);
    chk("mid_rst_shwdata", bus.s_hwdata, 32'h0);
    chk("mid_rst_hrdata", bus.m_hrdata, 32'h0);
    cyc();
    drop(1);
    bus.s_hready = 1'b1;
    cyc();
    rst = 1'b1;
    // randomized traffic against a transaction-level model
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      slv_mem[i] = ref_mem[i];
    end
    rr_last = MASTERS - 1;
    ncomp = 0;
    in_data = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pv[k] = 1'b0;
      pv_drv[k] = 1'b0;
    end
    for (int n = 0; n < 3000; n++) begin
      pv_prev = pv_drv;
      for (int k = 0; k < 2; k++) begin
        if (!pv[k] && $urandom_range(1, 0) == 1) begin
          pv[k] = 1'b1;
          pa[k] = {10'd0, 4'($urandom), 2'b00};
          pw[k] = 1'($urandom);
          pd[k] = $urandom;
        end
        bus.m_hsel[k] = pv[k] | 1'($urandom);
        bus.m_htrans[2*k +: 2] = pv[k] ? {1'b1, 1'($urandom)} : 2'b00;
        bus.m_haddr[16*k +: 16] = pa[k];
        bus.m_hwrite[k] = pw[k];
        bus.m_hwdata[32*k +: 32] = pd[k];
      end
      pv_drv = pv;
      bus.s_hresp = in_data && stall_left == 0 && err_inj;
      bus.s_hready = !in_data || (stall_left == 0 && !err_inj);
      bus.s_hrdata = in_data && stall_left == 0 ? slv_mem[s_a] : $urandom;
      smp();
      for (int k = 0; k < 2; k++) begin
        if (pv[k] && bus.m_hready[k]) begin
          chk("rnd_grant", 32'(k), 32'(exp_g));
          chk("rnd_hresp", bus.m_hresp[k], exp_err);
          if (!exp_err && pw[k]) ref_mem[pa[k][5:2]] = pd[k];
          else if (!exp_err) chk("rnd_hrdata", bus.m_hrdata, ref_mem[pa[k][5:2]]);
          rr_last = k;
          pv[k] = 1'b0;
          ncomp++;
        end else if (!pv[k]) chk("rnd_idle", {bus.m_hready[k], bus.m_hresp[k]}, 2'b10);
      end
      if (in_data) begin
        if (stall_left > 0) stall_left--;
        else begin
          if (!err_inj && s_w) slv_mem[s_a] = bus.s_hwdata;
          in_data = 1'b0;
        end
      end
      if (bus.s_hsel) begin
        exp_g = rr_last;
        for (int i = 2; i >= 1; i--) if (pv_prev[(rr_last + i) % 2]) exp_g = (rr_last + i) % 2;
        chk("rnd_shaddr", bus.s_haddr, pa[exp_g]);
        chk("rnd_shwrite", bus.s_hwrite, pw[exp_g]);
        chk("rnd_shtrans", bus.s_htrans, 2'b10);
        s_a = pa[exp_g][5:2];
        s_w = pw[exp_g];
        stall_left = $urandom_range(3, 0);
        err_inj = $urandom_range(7, 0) == 0;
        exp_err = err_inj;
        in_data = 1'b1;
      end
      cyc();
    end
    chk("rnd_progress", 32'(ncomp > 200), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
